// File: rtl/timer_irq_ctrl.sv
// Interrupt aggregator for the interval timers: edge-latched W1C pending bits, mask, missed-edge counters.
// Optional 32-bit edge counter on source 0 is built only when TIMER_IRQ_CTRL_TICK_CNT_EN is defined.
module timer_irq_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int MISS_W  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq
);

  localparam logic [2:0] A_PEND = 3'd0;
  localparam logic [2:0] A_MASK = 3'd1;
  localparam logic [2:0] A_RAW  = 3'd2;
  localparam logic [2:0] A_MISS = 3'd3;
  localparam logic [2:0] A_SEL  = 3'd4;

  logic                           wr;
  logic [NUM_SRC-1:0]             irq_d;
  logic [NUM_SRC-1:0]             edge_det;
  logic [NUM_SRC-1:0]             pending;
  logic [NUM_SRC-1:0]             pending_nxt;
  logic [NUM_SRC-1:0]             mask;
  logic [NUM_SRC-1:0]             mask_nxt;
  logic [NUM_SRC-1:0]             w1c;
  logic [NUM_SRC-1:0]             miss_clr;
  logic [3:0]                     sel;
  logic [NUM_SRC-1:0][MISS_W-1:0] missed;
  logic [MISS_W-1:0]              miss_sel;
  logic [15:0]                    rd_nxt;
  logic                           unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign edge_det     = irq_in & ~irq_d;
  assign unused_wdata = ^writedata;

  always_comb begin
    w1c      = '0;
    mask_nxt = mask;
    miss_clr = '0;
    miss_sel = '0;
    if (wr && address == A_PEND) w1c = writedata[NUM_SRC-1:0];
    if (wr && address == A_MASK) mask_nxt = writedata[NUM_SRC-1:0];
    // Only an in-range SEL can match a source, so out-of-range selects read 0 and ignore writes.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == 4'(i)) begin
        miss_sel    = missed[i];
        miss_clr[i] = wr && (address == A_MISS);
      end
    end
  end

  // A new edge re-sets the bit even if software clears it in the same cycle.
  assign pending_nxt = (pending & ~w1c) | edge_det;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_d   <= '0;
      pending <= '0;
      mask    <= '0;
      sel     <= '0;
      irq     <= 1'b0;
    end else begin
      irq_d   <= irq_in;
      pending <= pending_nxt;
      mask    <= mask_nxt;
      if (wr && address == A_SEL) sel <= writedata[3:0];
      irq     <= |(pending_nxt & mask_nxt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      missed <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (miss_clr[i])
          missed[i] <= '0;
        else if (edge_det[i] && pending[i] && !w1c[i] && missed[i] != '1)
          missed[i] <= missed[i] + MISS_W'(1);
      end
    end
  end

`ifdef TIMER_IRQ_CTRL_TICK_CNT_EN
  logic        rd;
  logic [31:0] tick;
  logic [15:0] tick_shadow;

  assign rd = chipselect & write_n;

  // The high half is captured when the low half is read so the pair is a consistent snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick        <= '0;
      tick_shadow <= '0;
    end else if (wr && address == 3'd5) begin
      tick        <= '0;
      tick_shadow <= '0;
    end else begin
      if (edge_det[0]) tick <= tick + 32'd1;
      if (rd && address == 3'd5) tick_shadow <= tick[31:16];
    end
  end
`endif

  always_comb begin
    rd_nxt = '0;
    case (address)
      A_PEND: rd_nxt[NUM_SRC-1:0] = pending;
      A_MASK: rd_nxt[NUM_SRC-1:0] = mask;
      A_RAW:  rd_nxt[NUM_SRC-1:0] = irq_in;
      A_MISS: rd_nxt[MISS_W-1:0]  = miss_sel;
      A_SEL:  rd_nxt[3:0]         = sel;
`ifdef TIMER_IRQ_CTRL_TICK_CNT_EN
      3'd5:   rd_nxt              = tick[15:0];
      3'd6:   rd_nxt              = tick_shadow;
`endif
      default: rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_nxt;
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl (NUM_SRC=4, MISS_W=8); read expectations go through a scoreboard queue.
module tb_timer_irq_ctrl;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [3:0]  irq_in;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  timer_irq_ctrl #(.NUM_SRC(4), .MISS_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cyc();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] a, input logic [15:0] exp, input string tag);
    logic [15:0] e;
    string       t;
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    cyc();
    chipselect = 1'b0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(readdata, e, t);
  endtask

  task automatic pulse(input logic [3:0] v);
    irq_in = v;
    cyc();
    irq_in = '0;
    cyc();
  endtask

  initial begin
    logic seen;
    reset_n    = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    irq_in     = '0;
    #2 reset_n = 1'b0;
    repeat (3) cyc();
    chk(readdata, 16'h0000, "reset_readdata");
    chk({15'd0, irq}, 16'h0000, "reset_irq");
    reset_n = 1'b1;
    cyc();

    // Single edge from a 3-clock pulse on source 1
    wr_reg(3'd1, 16'h000F);
    rd_reg(3'd1, 16'h000F, "mask_f");
    chk({15'd0, irq}, 16'h0000, "irq_before_edge");
    irq_in = 4'h2;
    cyc();
    chk({15'd0, irq}, 16'h0001, "irq_after_edge");
    cyc();
    cyc();
    irq_in = '0;
    rd_reg(3'd0, 16'h0002, "pend_src1");
    wr_reg(3'd4, 16'h0001);
    rd_reg(3'd3, 16'h0000, "missed_src1_zero");

    // Edge wins over a simultaneous W1C, and is not counted as missed
    pulse(4'h4);
    irq_in = 4'h4;
    wr_reg(3'd0, 16'h0004);
    irq_in = '0;
    rd_reg(3'd0, 16'h0006, "pend_edge_wins");
    wr_reg(3'd4, 16'h0002);
    rd_reg(3'd3, 16'h0000, "missed_src2_zero");
    chk({15'd0, irq}, 16'h0001, "irq_held");
    wr_reg(3'd0, 16'h000F);
    rd_reg(3'd0, 16'h0000, "pend_clear_all");
    chk({15'd0, irq}, 16'h0000, "irq_after_clear");

    // Saturation of the missed counter with irq masked
    wr_reg(3'd1, 16'h0000);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      irq_in = 4'h1;
      cyc();
      seen |= irq;
      irq_in = '0;
      cyc();
      seen |= irq;
    end
    chk({15'd0, seen}, 16'h0000, "irq_masked_300");
    wr_reg(3'd4, 16'h0000);
    rd_reg(3'd3, 16'h00FF, "missed_saturated");
    wr_reg(3'd3, 16'h0000);
    rd_reg(3'd3, 16'h0000, "missed_cleared");
    for (int i = 0; i < 3; i++) pulse(4'h2);
    wr_reg(3'd0, 16'h0002);
    rd_reg(3'd0, 16'h0001, "pend_src0_only");

    // MASK toggles irq with one clock of latency
    wr_reg(3'd1, 16'h0001);
    chk({15'd0, irq}, 16'h0001, "irq_mask_on");
    wr_reg(3'd1, 16'h0000);
    chk({15'd0, irq}, 16'h0000, "irq_mask_off");
    wr_reg(3'd1, 16'h0001);
    chk({15'd0, irq}, 16'h0001, "irq_mask_on_again");
    rd_reg(3'd0, 16'h0001, "pend_unchanged");

    // Out-of-range SEL
    wr_reg(3'd4, 16'h0009);
    rd_reg(3'd4, 16'h0009, "sel_9");
    rd_reg(3'd3, 16'h0000, "missed_sel_oor");
    wr_reg(3'd3, 16'hFFFF);
    wr_reg(3'd4, 16'h0001);
    rd_reg(3'd3, 16'h0002, "missed_src1_kept");

    // Asynchronous reset mid-sequence
    #2 reset_n = 1'b0;
    #1;
    chk(readdata, 16'h0000, "async_rst_readdata");
    chk({15'd0, irq}, 16'h0000, "async_rst_irq");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd_reg(3'd0, 16'h0000, "post_rst_pend");
    rd_reg(3'd1, 16'h0000, "post_rst_mask");
    rd_reg(3'd4, 16'h0000, "post_rst_sel");
    wr_reg(3'd4, 16'h0001);
    rd_reg(3'd3, 16'h0000, "post_rst_missed1");

    irq_in = 4'h5;
    rd_reg(3'd2, 16'h0005, "raw");
    irq_in = '0;
    cyc();
    wr_reg(3'd1, 16'hFFFF);
    rd_reg(3'd1, 16'h000F, "mask_upper_ignored");
    rd_reg(3'd7, 16'h0000, "addr7");

    // Line already high at reset release gives one edge
    reset_n = 1'b0;
    irq_in  = 4'h8;
    cyc();
    reset_n = 1'b1;
    cyc();
    rd_reg(3'd0, 16'h0008, "edge_at_release");
    irq_in  = '0;
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();

`ifdef TIMER_IRQ_CTRL_TICK_CNT_EN
    for (int i = 0; i < 5; i++) pulse(4'h1);
    rd_reg(3'd5, 16'h0005, "tick_lo");
    pulse(4'h1);
    rd_reg(3'd6, 16'h0000, "tick_shadow");
    rd_reg(3'd5, 16'h0006, "tick_lo_next");
    wr_reg(3'd5, 16'h0000);
    rd_reg(3'd5, 16'h0000, "tick_cleared");
`else
    pulse(4'h1);
    rd_reg(3'd5, 16'h0000, "addr5_absent");
    wr_reg(3'd6, 16'hFFFF);
    rd_reg(3'd6, 16'h0000, "addr6_absent");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
- Downstream consumer of the interval timers' irq outputs. Edge-detects up to 16 level interrupt lines and latches them into write-1-to-clear pending bits.
- Applies a per-source mask and drives one combined irq to the processor interrupt input.
- Counts missed timeouts per source, meaning a new edge arriving while that source's pending bit is still set.
- Presents a 16-bit Avalon-MM slave with the same timing as the timer: registered readdata, zero write wait states.

Parameters:
- NUM_SRC, 4, number of irq_in lines; legal range 1..16.
- MISS_W, 8, width of each per-source saturating missed counter; legal range 1..16.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  16  write data.
- readdata  out  16  registered read data; reset 0.
- irq_in  in  NUM_SRC  level irq lines from timers, synchronous to clk.
- irq  out  1  combined interrupt; reset 0.

Interface (already decided): one clock, clk; reset_n is asynchronous and active-low.

Behaviour:
- Write strobe: wr = chipselect & ~write_n. Reads need no strobe: readdata <= mux(address) every clock, giving 1-cycle latency.
- Register map, read view:
  - 0 PENDING: W1C. writedata[i]=1 clears pending[i].
  - 1 MASK: RW, reset 0.
  - 2 RAW: irq_in, read-only.
  - 3 MISSED: count of the source named by SEL. Any write clears that count.
  - 4 SEL: RW, 4 bits, reset 0.
  - 5 TICK_L and 6 TICK_H: optional feature.
  - Address 7: reads 0.
  - Bits at or above NUM_SRC read 0; writes to them are ignored.
- Edge detect:
  - irq_d <= irq_in each clock, reset 0.
  - edge[i] = irq_in[i] & ~irq_d[i].
  - A line already high when reset releases produces one edge on the first clock.
- Pending:
  - edge[i] sets pending[i] at the same clock edge.
  - Priority: edge set wins over a simultaneous W1C clear of the same bit.
- Missed counter:
  - Increments when edge[i] occurs while pending[i] is already 1 and no W1C of bit i happens that cycle.
  - Saturates at 2^MISS_W-1 and never wraps.
  - A clear write (address 3) in the same cycle as an increment of the selected source: clear wins, result 0.
- Out-of-range SEL (SEL >= NUM_SRC): address 3 reads 0; writes to address 3 are ignored.
- irq:
  - Registered: irq <= |(pending & MASK), evaluated on the next-state values.
  - Result: irq rises one clock after the edge sample and falls one clock after a clearing W1C or MASK write.
- Reset: all pending, MASK, SEL, missed counters, irq_d, readdata and irq go to 0 asynchronously. No state is retained.

Optional Feature:
- Macro: TIMER_IRQ_CTRL_TICK_CNT_EN.
- Defined:
  - 32-bit tick counter counts edge[0]; wraps 0xFFFFFFFF -> 0.
  - Reading address 5 returns tick[15:0] and, at the same clock, latches tick[31:16] into a shadow register. Reading address 6 returns the shadow.
  - Any write to address 5 clears tick and shadow. A write in the same cycle as edge[0] leaves tick = 0.
- Undefined: addresses 5 and 6 read 0, writes are ignored, and no counter logic is synthesised.

Test Plan:
- Reset release with irq_in=0, MASK=0xF: pulse irq_in[1] high for 3 clks -> PENDING reads 0x0002; irq=1 one clk after the edge; MISSED(SEL=1)=0.
- Set pending[2], write PENDING=0x0004 in the same cycle as a new irq_in[2] edge -> PENDING bit 2 stays 1; MISSED(SEL=2) stays 0; irq stays 1.
- MASK=0, then 300 edges on irq_in[0] without clearing -> irq stays 0; MISSED(SEL=0)=255 (saturated); a write to address 3 then reads back 0.
- MASK=0x1, pending[0] set, write MASK=0 -> irq falls one clk later; write MASK=1 -> irq rises again; PENDING unchanged at 0x0001.
- SEL=9 with NUM_SRC=4 -> address 3 reads 0x0000; a write to address 3 leaves all counters unchanged; reset_n asserted mid-sequence -> all readbacks 0 and irq=0 immediately.
- With TICK_CNT_EN, preload 65537 edges on irq_in[0] -> read 5 gives 0x0001, read 6 gives 0x0001; one more edge between the two reads -> read 6 still returns 0x0001 (shadow).
